mem_port_arbiter: RTL and testbench

//  Shares one single-ported unified memory between the fetch stage (IF) and the data/MEM stage (DM).

---
 rtl/mem_port_arbiter.sv | 129 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between instruction fetch (IF) and data (DM).
// One transaction outstanding; DM wins unless IF has waited STARVE_MAX DM grants.
module mem_port_arbiter #(
  parameter int DATAW      = 32,
  parameter int ADDRW      = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             if_req,
  input  logic [ADDRW-1:0] if_addr,
  input  logic             if_flush,
  output logic             if_gnt,
  output logic             if_rvalid,
  output logic [DATAW-1:0] if_rdata,
  input  logic             dm_req,
  input  logic             dm_we,
  input  logic [1:0]       dm_size,
  input  logic [ADDRW-1:0] dm_addr,
  input  logic [DATAW-1:0] dm_wdata,
  output logic             dm_gnt,
  output logic             dm_rvalid,
  output logic [DATAW-1:0] dm_rdata,
  output logic             mem_req,
  output logic             mem_we,
  output logic [1:0]       mem_size,
  output logic [ADDRW-1:0] mem_addr,
  output logic [DATAW-1:0] mem_wdata,
  input  logic             mem_ready,
  input  logic             mem_rvalid,
  input  logic [DATAW-1:0] mem_rdata,
  output logic             busy,
  output logic             protocol_err
);
  localparam int CNTW = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t           state;
  logic             owner_dm;
  logic             drop;
  logic [CNTW-1:0]  starve_cnt;
  logic             cmd_we;
  logic [1:0]       cmd_size;
  logic [ADDRW-1:0] cmd_addr;
  logic [DATAW-1:0] cmd_wdata;
  logic             if_live;
  logic             if_starved;
  logic             if_cancel;

  assign if_live    = if_req && !if_flush;
  assign if_starved = if_live && (starve_cnt == CNTW'(STARVE_MAX));
  // Grants are combinational; gating with reset keeps them low while reset is held.
  assign dm_gnt     = reset && (state == IDLE) && dm_req && !if_starved;
  assign if_gnt     = reset && (state == IDLE) && if_live && !dm_gnt;
  assign if_cancel  = !owner_dm && if_flush;

  assign mem_req   = (state == ISSUE);
  assign mem_we    = cmd_we;
  assign mem_size  = cmd_size;
  assign mem_addr  = cmd_addr;
  assign mem_wdata = cmd_wdata;
  assign busy      = (state != IDLE);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      owner_dm     <= 1'b0;
      drop         <= 1'b0;
      starve_cnt   <= '0;
      cmd_we       <= 1'b0;
      cmd_size     <= 2'b00;
      cmd_addr     <= '0;
      cmd_wdata    <= '0;
      if_rvalid    <= 1'b0;
      if_rdata     <= '0;
      dm_rvalid    <= 1'b0;
      dm_rdata     <= '0;
      protocol_err <= 1'b0;
    end else begin
      if_rvalid <= 1'b0;
      dm_rvalid <= 1'b0;
      if (mem_rvalid && state != WAIT) protocol_err <= 1'b1;
      case (state)
        IDLE: begin
          if (dm_gnt || if_gnt) begin
            state     <= ISSUE;
            owner_dm  <= dm_gnt;
            drop      <= 1'b0;
            cmd_we    <= dm_gnt && dm_we;
            cmd_size  <= dm_gnt ? dm_size : 2'b10;
            cmd_addr  <= dm_gnt ? dm_addr : if_addr;
            cmd_wdata <= dm_gnt ? dm_wdata : '0;
          end
          if (dm_gnt) begin
            if (!if_req)                                 starve_cnt <= '0;
            else if (starve_cnt != CNTW'(STARVE_MAX))    starve_cnt <= starve_cnt + 1'b1;
          end else if (if_gnt) begin
            starve_cnt <= '0;
          end
        end
        ISSUE: begin
          // A flush that races acceptance still cancels: the response is dropped later.
          if (mem_ready) begin
            state <= WAIT;
            if (if_cancel) drop <= 1'b1;
          end else if (if_cancel) begin
            state <= IDLE;
          end
        end
        WAIT: begin
          if (if_cancel) drop <= 1'b1;
          if (mem_rvalid) begin
            state <= IDLE;
            drop  <= 1'b0;
            if (owner_dm) begin
              dm_rvalid <= 1'b1;
              if (!cmd_we) dm_rdata <= mem_rdata;
            end else if (!(drop || if_flush)) begin
              if_rvalid <= 1'b1;
              if_rdata  <= mem_rdata;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter: a transaction-level reference model predicts
// grants and commands; a separate monitor matches rvalid pulses against a response queue.
module tb_mem_port_arbiter;
  localparam int DW = 32, AW = 32, SM = 4;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          if_req = 1'b0, if_flush = 1'b0;
  logic [AW-1:0] if_addr = '0;
  logic          dm_req = 1'b0, dm_we = 1'b0;
  logic [1:0]    dm_size = 2'b00;
  logic [AW-1:0] dm_addr = '0;
  logic [DW-1:0] dm_wdata = '0;
  logic          mem_ready = 1'b0, mem_rvalid = 1'b0;
  logic [DW-1:0] mem_rdata = '0;
  logic          if_gnt, if_rvalid, dm_gnt, dm_rvalid;
  logic [DW-1:0] if_rdata, dm_rdata, mem_wdata;
  logic          mem_req, mem_we, busy, protocol_err;
  logic [1:0]    mem_size;
  logic [AW-1:0] mem_addr;

  always #5 clock = ~clock;

  mem_port_arbiter #(.DATAW(DW), .ADDRW(AW), .STARVE_MAX(SM)) dut (
    .clock(clock), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_size(dm_size), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_size(mem_size), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .busy(busy), .protocol_err(protocol_err)
  );

  int checks = 0, errors = 0;
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct { bit is_if; bit st; logic [DW-1:0] data; int due; } resp_t;
  resp_t rq[$];
  bit mon_en = 1'b0;
  logic [DW-1:0] exp_if_rdata = '0, exp_dm_rdata = '0;

  always @(negedge clock) begin : monitor
    resp_t r;
    if (!mon_en) begin
      exp_if_rdata = '0;
      exp_dm_rdata = '0;
    end else begin
      if (rq.size() != 0 && rq[0].due <= cyc) begin
        r = rq.pop_front();
        chk("rvalid_owner", {if_rvalid, dm_rvalid}, r.is_if ? 2'b10 : 2'b01);
        if (r.is_if) exp_if_rdata = r.data;
        else if (!r.st) exp_dm_rdata = r.data;
      end else if (if_rvalid || dm_rvalid) begin
        chk("spurious_rvalid", {if_rvalid, dm_rvalid}, 2'b00);
      end
      chk("if_rdata", if_rdata, exp_if_rdata);
      chk("dm_rdata", dm_rdata, exp_dm_rdata);
    end
  end

  // Reference model: lifecycle of the single outstanding transaction.
  // ph 0 = none, 1 = granted but not yet accepted by memory, 2 = accepted, awaiting completion.
  int            ph, starve;
  bit            own_if, cancel, exp_perr;
  logic [AW-1:0] c_addr;
  bit            c_we;
  logic [1:0]    c_size;
  logic [DW-1:0] c_wdata;
  bit            mem_pend, got_if, got_dm;
  int            mem_dly;
  string         gseq;

  task automatic model_reset();
    ph = 0; starve = 0; own_if = 0; cancel = 0; exp_perr = 0;
    mem_pend = 0; mem_dly = 0; got_if = 0; got_dm = 0;
    rq.delete();
  endtask

  // mode: 0 random, 1 both requesters saturate / fast memory, 2 stray mem_rvalid,
  //       3 fetch only and memory never answers, 4 drain (no new requests)
  task automatic step(input int mode);
    bit eg_dm, eg_if;
    @(posedge clock); #1;
    if (got_if) if_req = 1'b0;
    if (got_dm) dm_req = 1'b0;
    if (!if_req && (mode == 1 || mode == 3 || (mode == 0 && $urandom_range(0, 2) == 0))) begin
      if_req  = 1'b1;
      if_addr = $urandom & 32'hFFFF_FFFC;
    end
    if (!dm_req && (mode == 1 || (mode == 0 && $urandom_range(0, 2) == 0))) begin
      dm_req   = 1'b1;
      dm_we    = 1'($urandom_range(0, 1));
      dm_size  = 2'($urandom_range(0, 2));
      dm_addr  = $urandom;
      dm_wdata = $urandom;
    end
    if_flush   = (mode == 0) && ($urandom_range(0, 7) == 0);
    mem_ready  = (mode != 0) || ($urandom_range(0, 3) != 0);
    mem_rvalid = (mode == 2);
    if (mode == 2) mem_rdata = $urandom;
    if (mem_pend && mode != 3) begin
      if (mem_dly == 0) begin
        mem_rvalid = 1'b1;
        mem_rdata  = $urandom;
        mem_pend   = 1'b0;
      end else mem_dly--;
    end
    @(negedge clock);
    eg_dm = (ph == 0) && dm_req && !(if_req && !if_flush && starve == SM);
    eg_if = (ph == 0) && !eg_dm && if_req && !if_flush;
    chk("if_gnt", if_gnt, eg_if);
    chk("dm_gnt", dm_gnt, eg_dm);
    chk("busy", busy, ph != 0);
    chk("mem_req", mem_req, ph == 1);
    chk("protocol_err", protocol_err, exp_perr);
    if (ph == 1) begin
      chk("mem_addr", mem_addr, c_addr);
      chk("mem_we", mem_we, c_we);
      chk("mem_size", mem_size, c_size);
      if (c_we) chk("mem_wdata", mem_wdata, c_wdata);
    end
    if (dm_gnt) gseq = {gseq, "D"};
    if (if_gnt) gseq = {gseq, "I"};
    if (mem_rvalid && ph != 2) exp_perr = 1;
    case (ph)
      0: if (eg_dm || eg_if) begin
        ph = 1; own_if = eg_if; cancel = 0;
        c_addr  = eg_dm ? dm_addr : if_addr;
        c_we    = eg_dm && dm_we;
        c_size  = eg_dm ? dm_size : 2'b10;
        c_wdata = dm_wdata;
        if (eg_if || !if_req) starve = 0;
        else if (starve < SM) starve++;
      end
      1: if (mem_ready) begin
        ph = 2;
        if (own_if && if_flush) cancel = 1;
      end else if (own_if && if_flush) ph = 0;
      default: begin
        if (own_if && if_flush) cancel = 1;
        if (mem_rvalid) begin
          if (!(own_if && cancel)) rq.push_back('{is_if: own_if, st: c_we, data: mem_rdata, due: cyc + 1});
          ph = 0;
        end
      end
    endcase
    if (mem_req && mem_ready && !mem_pend) begin
      mem_pend = 1'b1;
      mem_dly  = (mode == 0) ? $urandom_range(0, 3) : 0;
    end
    got_if = if_gnt;
    got_dm = dm_gnt;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ctl"}, {if_gnt, dm_gnt, if_rvalid, dm_rvalid, mem_req, mem_we, busy, protocol_err}, 8'h00);
    chk({tag, "_rdata"}, {if_rdata, dm_rdata}, 64'h0);
    chk({tag, "_cmd"}, {mem_size, mem_addr}, 34'h0);
    chk({tag, "_wdata"}, mem_wdata, 32'h0);
  endtask

  task automatic drain();
    for (int i = 0; i < 200; i++) begin
      if (ph == 0 && !if_req && !dm_req && !mem_pend && rq.size() == 0) break;
      step(4);
    end
    step(4);
    chk("drain_idle", {ph != 0, rq.size() != 0, busy}, 3'b000);
  endtask

  initial begin
    model_reset();
    #2 reset = 1'b0;
    if_req = 1'b1; dm_req = 1'b1;
    #1 chk_zero("reset");
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk_zero("reset_held");
    if_req = 1'b0; dm_req = 1'b0;
    reset = 1'b1;
    mon_en = 1'b1;

    // Both requesters held, memory at minimum latency: IF gets every fifth grant.
    gseq = "";
    repeat (40) step(1);
    checks++;
    if (gseq.len() < 10 || gseq.substr(0, 9) != "DDDDIDDDDI") begin
      errors++;
      $display("FAIL starve_order actual=%s required=DDDDIDDDDI...", gseq);
    end
    drain();

    repeat (3000) step(0);
    drain();

    // Completion with nothing outstanding: ignored and latched as a protocol error.
    step(2);
    repeat (3) step(4);

    // Reset while a fetch waits for memory.
    for (int i = 0; i < 20 && ph != 2; i++) step(3);
    chk("reached_wait", busy, 1'b1);
    @(posedge clock); #1;
    mon_en = 1'b0;
    reset = 1'b0;
    #1 chk_zero("reset_wait");
    @(negedge clock);
    chk_zero("reset_wait_held");
    if_req = 1'b0; dm_req = 1'b0; mem_rvalid = 1'b0;
    model_reset();
    reset = 1'b1;
    @(negedge clock);
    mon_en = 1'b1;
    repeat (300) step(0);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule
